npn_tt_eval: RTL and testbench

NPN_TT_EVAL -- requirements
Module: npn_tt_eval

---
 rtl/npn_tt_eval_if.sv | 47 ++++
 rtl/npn_tt_eval.sv | 135 +++++++++++++
 tb/tb_npn_tt_eval.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/npn_tt_eval_if.sv
// Handshake and configuration bundle for the NPN truth-table evaluator.
// master = traffic source / configurator, slave = evaluator.
// PW must match the evaluator: $clog2(N_IN) bits per permutation field.
interface npn_tt_eval_if #(
  parameter int N_IN = 4
) ();
  localparam int PW = $clog2(N_IN);
  localparam int TW = 2**N_IN;

  // configuration port
  logic               cfg_we;
  logic [TW-1:0]      cfg_tt;
  logic [N_IN-1:0]    cfg_neg_in;
  logic [N_IN*PW-1:0] cfg_perm;
  logic               cfg_neg_out;
  logic               cfg_busy;
  logic               cfg_err;

  // input stream
  logic               in_valid;
  logic               in_ready;
  logic [N_IN-1:0]    in_x;

  // output stream
  logic               out_valid;
  logic               out_ready;
  logic               out_y;
  logic [15:0]        out_count;

  modport master (
    output cfg_we, cfg_tt, cfg_neg_in, cfg_perm, cfg_neg_out,
    input  cfg_busy, cfg_err,
    output in_valid, in_x,
    input  in_ready,
    input  out_valid, out_y, out_count,
    output out_ready
  );

  modport slave (
    input  cfg_we, cfg_tt, cfg_neg_in, cfg_perm, cfg_neg_out,
    output cfg_busy, cfg_err,
    input  in_valid, in_x,
    output in_ready,
    output out_valid, out_y, out_count,
    input  out_ready
  );
endinterface

// File: rtl/npn_tt_eval.sv
// Evaluates a configurable boolean function under input negation/permutation and output negation.
// Latency: 2 cycles input transfer -> out_valid; 1 result/cycle with out_ready high.
// Backpressure: 2-entry pipeline; in_ready drops when both stages are full and out is stalled.
module npn_tt_eval #(
  parameter int                 N_IN    = 4,
  parameter logic [2**N_IN-1:0] INIT_TT = 16'h16E9
) (
  input  logic         clk,
  input  logic         rst,
  npn_tt_eval_if.slave bus
);
  localparam int PW = $clog2(N_IN);
  localparam int TW = 2**N_IN;

  // Identity permutation: field i selects input i.
  function automatic logic [N_IN*PW-1:0] f_identity();
    logic [N_IN*PW-1:0] p;
    p = '0;
    for (int i = 0; i < N_IN; i++) p[PW*i +: PW] = PW'(i);
    return p;
  endfunction

  localparam logic [N_IN*PW-1:0] ID_PERM = f_identity();

  // configuration state
  logic [TW-1:0]      r_tt;
  logic [N_IN-1:0]    r_neg_in;
  logic [N_IN*PW-1:0] r_perm;
  logic               r_neg_out;
  logic               r_err;

  // pipeline state
  logic               r_s1_vld;
  logic [N_IN-1:0]    r_s1_v;
  logic               r_s2_vld;
  logic               r_s2_y;
  logic [15:0]        r_count;

  logic               w_busy;
  logic               w_s2_free;
  logic               w_s1_free;
  logic               w_in_ready;
  logic               w_perm_ok;
  logic               w_cfg_ok;
  logic [N_IN-1:0]    w_u;
  logic [N_IN-1:0]    w_v;
  logic               w_y;

  assign w_busy     = r_s1_vld | r_s2_vld;
  // A stage may load when its own content leaves this cycle or it is empty.
  assign w_s2_free  = ~r_s2_vld | bus.out_ready;
  assign w_s1_free  = ~r_s1_vld | w_s2_free;
  // No input is taken while a config write is presented, so config never races data.
  assign w_in_ready = ~rst & ~bus.cfg_we & w_s1_free;
  assign w_cfg_ok   = ~w_busy & ~bus.in_valid & w_perm_ok;

  // Reject any permutation with an out-of-range or repeated field.
  always_comb begin
    w_perm_ok = 1'b1;
    for (int i = 0; i < N_IN; i++) begin
      if (int'(bus.cfg_perm[PW*i +: PW]) >= N_IN) w_perm_ok = 1'b0;
      for (int j = i + 1; j < N_IN; j++) begin
        if (bus.cfg_perm[PW*i +: PW] == bus.cfg_perm[PW*j +: PW]) w_perm_ok = 1'b0;
      end
    end
  end

  // Stage-1 datapath: negate inputs, then gather through the permutation.
  always_comb begin
    w_u = bus.in_x ^ r_neg_in;
    w_v = '0;
    for (int i = 0; i < N_IN; i++) w_v[i] = w_u[r_perm[PW*i +: PW]];
  end

  // Stage-2 datapath: truth-table lookup on the stage-1 minterm index.
  assign w_y = r_tt[r_s1_v] ^ r_neg_out;

  // Config registers and sticky error; config only changes with the pipeline empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tt      <= INIT_TT;
      r_neg_in  <= '0;
      r_perm    <= ID_PERM;
      r_neg_out <= 1'b0;
      r_err     <= 1'b0;
    end else if (bus.cfg_we) begin
      if (w_cfg_ok) begin
        r_tt      <= bus.cfg_tt;
        r_neg_in  <= bus.cfg_neg_in;
        r_perm    <= bus.cfg_perm;
        r_neg_out <= bus.cfg_neg_out;
      end else begin
        r_err     <= 1'b1;
      end
    end
  end

  // Two-stage pipeline; out_y holds its value while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s1_v   <= '0;
      r_s2_vld <= 1'b0;
      r_s2_y   <= 1'b0;
    end else begin
      if (bus.in_valid && w_in_ready) begin
        r_s1_vld <= 1'b1;
        r_s1_v   <= w_v;
      end else if (w_s2_free) begin
        r_s1_vld <= 1'b0;
      end
      if (w_s2_free) begin
        r_s2_vld <= r_s1_vld;
        if (r_s1_vld) r_s2_y <= w_y;
      end
    end
  end

  // Completed output transfers, free-running and wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (r_s2_vld && bus.out_ready) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_vld;
  assign bus.out_y     = r_s2_y;
  assign bus.out_count = r_count;
  assign bus.cfg_busy  = w_busy;
  assign bus.cfg_err   = r_err;

endmodule

// File: tb/tb_npn_tt_eval.sv
// Scoreboard bench for npn_tt_eval: a monitor predicts each result from a
// function-level model at input acceptance and compares at output transfer.
// Directed scenarios first, then a randomized phase with random configs.
module tb_npn_tt_eval;
  localparam int N_IN = 4;
  localparam int PW   = 2;
  localparam logic [15:0] INIT = 16'h16E9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  npn_tt_eval_if #(.N_IN(N_IN)) bus ();

  npn_tt_eval #(.N_IN(N_IN), .INIT_TT(INIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  logic [15:0] m_tt;
  logic [3:0]  m_neg_in;
  logic [7:0]  m_perm;
  logic        m_neg_out;
  logic        m_err;
  logic [15:0] m_count;
  logic        exp_q[$];
  int          in_log[$];
  int          out_log[$];
  logic        y_log[$];
  int          cyc = 0;
  logic        hold_vld = 1'b0;
  logic        hold_y   = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired (t=%0t)", nm, $time);
  endtask

  function automatic int field(input logic [7:0] p, input int i);
    return int'((p >> (PW * i)) & 8'(3));
  endfunction

  function automatic bit perm_ok(input logic [7:0] p);
    bit seen [N_IN];
    for (int i = 0; i < N_IN; i++) seen[i] = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (field(p, i) >= N_IN || seen[field(p, i)]) return 1'b0;
      seen[field(p, i)] = 1'b1;
    end
    return 1'b1;
  endfunction

  // Minterm index: bit i is the negated input chosen by permutation field i.
  function automatic logic ref_y(input logic [3:0] x);
    int idx = 0;
    for (int i = 0; i < N_IN; i++)
      idx += int'(((x ^ m_neg_in) >> field(m_perm, i)) & 4'd1) * (1 << i);
    return m_tt[idx] ^ m_neg_out;
  endfunction

  // Monitor: samples on the falling edge what the next rising edge will do.
  always @(negedge clk) begin
    bit busy_now;
    cyc++;
    if (rst) begin
      check("in_ready_in_rst", bus.in_ready, 0);
      exp_q.delete();
      m_tt = INIT; m_neg_in = '0; m_perm = 8'hE4; m_neg_out = 1'b0;
      m_err = 1'b0; m_count = '0; hold_vld = 1'b0;
    end else begin
      busy_now = (exp_q.size() != 0);
      check("cfg_busy", bus.cfg_busy, busy_now);
      check("cfg_err", bus.cfg_err, m_err);
      check("out_count", bus.out_count, m_count);
      check("in_ready", bus.in_ready, !bus.cfg_we && (exp_q.size() < 2 || bus.out_ready));
      if (hold_vld) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_y", bus.out_y, hold_y);
      end
      hold_vld = bus.out_valid && !bus.out_ready;
      hold_y   = bus.out_y;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          check("out_y", bus.out_y, exp_q.pop_front());
        end
        m_count = m_count + 16'd1;
        out_log.push_back(cyc);
        y_log.push_back(bus.out_y);
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_y(bus.in_x));
        in_log.push_back(cyc);
      end
      if (bus.cfg_we) begin
        if (!busy_now && !bus.in_valid && perm_ok(bus.cfg_perm)) begin
          m_tt = bus.cfg_tt; m_neg_in = bus.cfg_neg_in;
          m_perm = bus.cfg_perm; m_neg_out = bus.cfg_neg_out;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents x and waits for acceptance; leaves in_valid high for back-to-back use.
  task automatic push(input logic [3:0] x);
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (bus.in_ready) begin
        tick();
        return;
      end
      tick();
    end
    fail("push_timeout");
  endtask

  task automatic cfg(input logic [15:0] tt, input logic [3:0] ni, input logic [7:0] p, input logic no);
    bus.in_valid = 1'b0;
    bus.cfg_tt = tt; bus.cfg_neg_in = ni; bus.cfg_perm = p; bus.cfg_neg_out = no;
    bus.cfg_we = 1'b1;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 0 && !bus.cfg_busy) return;
      tick();
    end
    fail("drain_timeout");
  endtask

  task automatic single(input logic [3:0] x, input logic exp_y, input string nm);
    push(x);
    drain();
    tick();
    check(nm, y_log[y_log.size()-1], exp_y);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", bus.in_ready, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          i_in, i_out, acc, oc;
    logic [15:0] cnt0;
    logic [3:0]  items [3];
    logic [7:0]  rp;
    int          a [4];

    rst = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_tt = '0; bus.cfg_neg_in = '0; bus.cfg_perm = '0;
    bus.cfg_neg_out = 1'b0; bus.in_valid = 1'b0; bus.in_x = '0; bus.out_ready = 1'b1;
    repeat (3) tick();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_y", bus.out_y, 0);
    check("rst_out_count", bus.out_count, 0);
    check("rst_cfg_err", bus.cfg_err, 0);
    check("rst_cfg_busy", bus.cfg_busy, 0);
    rst = 1'b0;
    #1;
    check("in_ready_first", bus.in_ready, 1);

    // default function, back to back, latency and throughput
    i_in = in_log.size(); i_out = out_log.size();
    push(4'h0); push(4'h1); push(4'h7); push(4'hC);
    drain(); tick();
    check("b2b_y0", y_log[i_out+0], 1);
    check("b2b_y1", y_log[i_out+1], 0);
    check("b2b_y2", y_log[i_out+2], 1);
    check("b2b_y3", y_log[i_out+3], 1);
    for (int k = 0; k < 4; k++) check("latency", out_log[i_out+k] - in_log[i_in+k], 2);
    check("b2b_count", bus.out_count, 4);

    // input and output negation
    cfg(INIT, 4'h1, 8'hE4, 1'b0);
    single(4'h0, 1'b0, "neg_in_y");
    cfg(INIT, 4'h0, 8'hE4, 1'b1);
    single(4'h0, 1'b0, "neg_out_y");

    // swap x0 and x3
    cfg(INIT, 4'h0, 8'h27, 1'b0);
    single(4'h7, 1'b0, "perm_swap_y");
    cfg(INIT, 4'h0, 8'hE4, 1'b0);
    single(4'h7, 1'b1, "perm_ident_y");

    // stall: only two items fit
    items[0] = 4'h3; items[1] = 4'h5; items[2] = 4'h9;
    cnt0 = bus.out_count;
    bus.out_ready = 1'b0;
    acc = 0;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.in_x = items[acc];
      #1;
      if (bus.in_ready) acc++;
      tick();
    end
    check("stall_accepted", acc, 2);
    #1;
    check("stall_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    push(items[2]);
    drain(); tick();
    check("stall_count", bus.out_count - cnt0, 3);

    // bad permutation rejected, config kept
    cfg(16'h0000, 4'h0, 8'h00, 1'b0);
    tick();
    check("bad_perm_err", bus.cfg_err, 1);
    single(4'h0, 1'b1, "bad_perm_cfg_kept");

    // write while busy rejected, in-flight results untouched
    do_reset(2);
    check("err_cleared", bus.cfg_err, 0);
    bus.out_ready = 1'b0;
    push(4'h1); push(4'h7);
    cfg(16'h0000, 4'h0, 8'hE4, 1'b1);
    check("busy_cfg_err", bus.cfg_err, 1);
    drain(); tick();
    check("busy_keep_y0", y_log[y_log.size()-2], 0);
    check("busy_keep_y1", y_log[y_log.size()-1], 1);
    single(4'h0, 1'b1, "busy_cfg_kept");

    // reset with two items in flight
    bus.out_ready = 1'b0;
    push(4'h0); push(4'h1);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    bus.out_ready = 1'b1;
    tick();
    oc = out_log.size();
    do_reset(1);
    repeat (5) tick();
    check("rst_no_out", out_log.size() - oc, 0);
    check("rst_count", bus.out_count, 0);

    // randomized traffic and configuration
    for (int c = 0; c < 600; c++) begin
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.in_x      = 4'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.cfg_we    = ($urandom_range(0, 19) == 0);
      if (bus.cfg_we) begin
        if ($urandom_range(0, 1) == 0) bus.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) a[k] = k;
        for (int k = 3; k > 0; k--) begin
          int j, t;
          j = $urandom_range(0, k);
          t = a[k]; a[k] = a[j]; a[j] = t;
        end
        rp = {2'(a[3]), 2'(a[2]), 2'(a[1]), 2'(a[0])};
        if ($urandom_range(0, 3) == 0) rp = 8'($urandom);
        bus.cfg_perm    = rp;
        bus.cfg_tt      = 16'($urandom);
        bus.cfg_neg_in  = 4'($urandom);
        bus.cfg_neg_out = 1'($urandom);
      end
      tick();
    end
    bus.cfg_we = 1'b0;
    drain();
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
